pwm_ramp_ctrl: RTL and testbench

//  Soft-start/soft-stop sequencer driving the 4-bit duty_cycle input of the pwm block.

---
 rtl/pwm_ctrl_pkg.sv | 30 +++
 rtl/pwm_period_timer.sv | 25 ++
 rtl/pwm_ramp_ctrl.sv | 121 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types and step helper for PWM duty ramp controllers
// Contents: ramp_state_t FSM encoding, DUTY_W_DEF default width, step_toward() saturating step.
package pwm_ctrl_pkg;

    localparam int DUTY_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // One step of size 'step' from duty toward target, clamped so it never
    // overshoots. Signed arithmetic keeps a downward step from wrapping below 0.
    function automatic logic signed [31:0] step_toward(
        input logic signed [31:0] duty,
        input logic signed [31:0] target,
        input logic signed [31:0] step
    );
        logic signed [31:0] up;
        logic signed [31:0] dn;
        up = duty + step;
        dn = duty - step;
        if (target > duty) begin
            return (up > target) ? target : up;
        end
        return (dn < target) ? target : dn;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// rtl/pwm_period_timer.sv - free-running PWM period counter with boundary strobe
// Ports: clk, rst (sync, active-high), enable (count/hold),
//        boundary (high on the last cycle of a 2**DUTY_W-cycle period while enabled).
module pwm_period_timer #(
    parameter int DUTY_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic boundary
);

    logic [DUTY_W-1:0] period_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (enable) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign boundary = enable & (period_cnt == {DUTY_W{1'b1}});

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start/soft-stop sequencer for the pwm duty_cycle input
// Ports: clk, rst (sync, active-high), enable (run/freeze), kill (emergency 0%),
//        tgt_valid/tgt_duty/tgt_ready (target handshake), duty_cycle (to pwm),
//        busy (ramp in progress), done (1-cycle pulse on reaching the target).
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int STEP         = 1,
    parameter int RAMP_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              kill,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

    localparam int PW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(RAMP_PERIODS - 1);

    ramp_state_t       state, state_n;
    logic [PW-1:0]     per_cnt, per_cnt_n;
    logic [DUTY_W-1:0] target, target_n;
    logic [DUTY_W-1:0] duty_n;
    logic              done_n;
    logic              boundary;

    logic signed [31:0] duty_ext;
    logic signed [31:0] tgt_ext;
    logic signed [31:0] stepped;

    pwm_period_timer #(
        .DUTY_W(DUTY_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .boundary(boundary)
    );

    assign duty_ext = $signed({{(32-DUTY_W){1'b0}}, duty_cycle});
    assign tgt_ext  = $signed({{(32-DUTY_W){1'b0}}, target});
    assign stepped  = step_toward(duty_ext, tgt_ext, STEP);

    assign tgt_ready = (state == IDLE) & ~kill;

    always_comb begin
        state_n   = state;
        duty_n    = duty_cycle;
        per_cnt_n = per_cnt;
        target_n  = target;
        done_n    = 1'b0;

        if (kill) begin
            // Kill wins over both accept and step; no done pulse on this path.
            state_n   = IDLE;
            duty_n    = '0;
            per_cnt_n = '0;
            target_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        target_n  = tgt_duty;
                        per_cnt_n = '0;
                        if (tgt_duty > duty_cycle) begin
                            state_n = RAMP_UP;
                        end else if (tgt_duty < duty_cycle) begin
                            state_n = RAMP_DOWN;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    // boundary already includes enable, so a frozen ramp holds here.
                    if (boundary) begin
                        if (per_cnt != PER_LAST) begin
                            per_cnt_n = per_cnt + 1'b1;
                        end else begin
                            per_cnt_n = '0;
                            duty_n    = stepped[DUTY_W-1:0];
                            if (stepped == tgt_ext) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            per_cnt    <= '0;
            target     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            per_cnt    <= per_cnt_n;
            target     <= target_n;
            done       <= done_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl (STEP=1 and STEP=2 instances)
module tb_pwm_ramp_ctrl;

    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       kill;
    logic       tgt_valid;
    logic [3:0] tgt_duty;

    logic       ready_o [2];
    logic [3:0] duty_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.DUTY_W(4), .STEP(1), .RAMP_PERIODS(RP)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .kill      (kill),
        .tgt_valid (tgt_valid),
        .tgt_duty  (tgt_duty),
        .tgt_ready (ready_o[0]),
        .duty_cycle(duty_o[0]),
        .busy      (busy_o[0]),
        .done      (done_o[0])
    );

    pwm_ramp_ctrl #(.DUTY_W(4), .STEP(2), .RAMP_PERIODS(RP)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .kill      (kill),
        .tgt_valid (tgt_valid),
        .tgt_duty  (tgt_duty),
        .tgt_ready (ready_o[1]),
        .duty_cycle(duty_o[1]),
        .busy      (busy_o[1]),
        .done      (done_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: current duty, latched target, whether a ramp is active,
    // how many period boundaries have passed since the accept, and done.
    bit started = 1'b0;
    int pos = 0;
    int cyc = 0;
    int m_duty [2];
    int m_tgt  [2];
    int m_nb   [2];
    bit m_act  [2];
    bit m_done [2];

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    always @(posedge clk) begin
        bit bnd;
        bnd = enable && (pos == 15);
        if (rst) begin
            started = 1'b1;
            pos = 0;
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                m_duty[k] = 0; m_tgt[k] = 0; m_nb[k] = 0;
                m_act[k] = 1'b0; m_done[k] = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            if (enable) pos = (pos + 1) % 16;
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 1'b0;
                if (kill) begin
                    m_duty[k] = 0; m_tgt[k] = 0; m_act[k] = 1'b0;
                end else if (!m_act[k]) begin
                    if (tgt_valid) begin
                        m_tgt[k] = int'(tgt_duty);
                        m_nb[k] = 0;
                        if (m_tgt[k] == m_duty[k]) m_done[k] = 1'b1;
                        else m_act[k] = 1'b1;
                    end
                end else if (bnd) begin
                    m_nb[k] = m_nb[k] + 1;
                    if (m_nb[k] % RP == 0) begin
                        if (m_tgt[k] > m_duty[k])
                            m_duty[k] = (m_duty[k] + step_of(k) > m_tgt[k]) ? m_tgt[k] : m_duty[k] + step_of(k);
                        else
                            m_duty[k] = (m_duty[k] - step_of(k) < m_tgt[k]) ? m_tgt[k] : m_duty[k] - step_of(k);
                        if (m_duty[k] == m_tgt[k]) begin
                            m_act[k] = 1'b0;
                            m_done[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk(k ? "model_duty2" : "model_duty1", int'(duty_o[k]), m_duty[k]);
                chk(k ? "model_busy2" : "model_busy1", int'(busy_o[k]), int'(m_act[k]));
                chk(k ? "model_done2" : "model_done1", int'(done_o[k]), int'(m_done[k]));
                chk(k ? "model_ready2" : "model_ready1", int'(ready_o[k]), int'(!m_act[k] && !kill));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic to_cycle(input int n);
        int guard;
        guard = 0;
        while (guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
            if (cyc >= n) break;
        end
        #1;
        chk("to_cycle_reached", cyc, n);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input int v);
        tgt_valid = 1'b1;
        tgt_duty  = 4'(v);
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((m_act[0] || m_act[1]) && i < budget) begin
            tick();
            i++;
        end
        chk("wait_idle_in_budget", int'(i < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [$];
        int exp_q [$];
        int last;
        int dones;
        int i;

        rst = 1'b1; enable = 1'b1; kill = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state, cycle 0
        chk("rst_duty", int'(duty_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_done", int'(done_o[0]), 0);
        chk("rst_ready", int'(ready_o[0]), 1);

        // 1: ramp up to 3, accept at cycle 3
        to_cycle(3);
        tgt_valid = 1'b1; tgt_duty = 4'd3;
        to_cycle(4);
        tgt_valid = 1'b0;
        chk("t1_busy_c4", int'(busy_o[0]), 1);
        to_cycle(31); chk("t1_duty_c31", int'(duty_o[0]), 0);
        to_cycle(32); chk("t1_duty_c32", int'(duty_o[0]), 1);
        to_cycle(63); chk("t1_duty_c63", int'(duty_o[0]), 1);
        to_cycle(64); chk("t1_duty_c64", int'(duty_o[0]), 2);
        chk("t1_step2_duty_c64", int'(duty_o[1]), 3);
        to_cycle(95);
        chk("t1_duty_c95", int'(duty_o[0]), 2);
        chk("t1_busy_c95", int'(busy_o[0]), 1);
        chk("t1_done_c95", int'(done_o[0]), 0);
        to_cycle(96);
        chk("t1_duty_c96", int'(duty_o[0]), 3);
        chk("t1_done_c96", int'(done_o[0]), 1);
        chk("t1_busy_c96", int'(busy_o[0]), 0);
        to_cycle(97);
        chk("t1_done_c97", int'(done_o[0]), 0);

        // 2: STEP=2 ramp down 5 -> 0 must go 3,1,0 with a single done
        accept(5);
        wait_idle(400);
        chk("t2_start_duty1", int'(duty_o[0]), 5);
        chk("t2_start_duty2", int'(duty_o[1]), 5);
        accept(0);
        last = 5; dones = 0; i = 0;
        while ((m_act[0] || m_act[1]) && i < 600) begin
            tick();
            i++;
            if (int'(duty_o[1]) != last) begin
                last = int'(duty_o[1]);
                seq.push_back(last);
            end
            if (done_o[1]) dones++;
        end
        chk("t2_loop_in_budget", int'(i < 600), 1);
        exp_q = '{3, 1, 0};
        chk("t2_seq_len", seq.size(), exp_q.size());
        for (int j = 0; j < seq.size() && j < exp_q.size(); j++)
            chk("t2_seq_val", seq[j], exp_q[j]);
        chk("t2_done_count", dones, 1);
        chk("t2_final_duty1", int'(duty_o[0]), 0);

        // 3: equal target leaves state alone and pulses done next cycle
        accept(7);
        wait_idle(600);
        chk("t3_pre_duty1", int'(duty_o[0]), 7);
        chk("t3_pre_duty2", int'(duty_o[1]), 7);
        accept(7);
        chk("t3_done1", int'(done_o[0]), 1);
        chk("t3_done2", int'(done_o[1]), 1);
        chk("t3_busy1", int'(busy_o[0]), 0);
        chk("t3_duty1", int'(duty_o[0]), 7);
        tick();
        chk("t3_done1_after", int'(done_o[0]), 0);
        chk("t3_duty1_after", int'(duty_o[0]), 7);

        // 4: target held valid during a ramp is only taken once idle
        accept(9);
        tgt_valid = 1'b1; tgt_duty = 4'd15;
        #1;
        chk("t4_ready_mid_ramp", int'(ready_o[0]), 0);
        i = 0;
        while (!done_o[0] && i < 200) begin
            tick();
            i++;
        end
        chk("t4_done_seen", int'(done_o[0]), 1);
        chk("t4_ready_at_done", int'(ready_o[0]), 1);
        chk("t4_duty_at_done", int'(duty_o[0]), 9);
        tick();
        tgt_valid = 1'b0;
        chk("t4_busy_after_accept", int'(busy_o[0]), 1);

        // 5: kill mid-ramp (duty 9 -> 15), with a competing target offered
        repeat (3) tick();
        kill = 1'b1; tgt_valid = 1'b1; tgt_duty = 4'd4;
        #1;
        chk("t5_ready_during_kill", int'(ready_o[0]), 0);
        tick();
        kill = 1'b0; tgt_valid = 1'b0;
        chk("t5_duty_after_kill", int'(duty_o[0]), 0);
        chk("t5_busy_after_kill", int'(busy_o[0]), 0);
        chk("t5_done_after_kill", int'(done_o[0]), 0);
        tick();
        chk("t5_duty_no_accept", int'(duty_o[0]), 0);
        chk("t5_busy_no_accept", int'(busy_o[0]), 0);

        // 6: freeze with enable=0 for 40 cycles, then resume with same per_cnt
        accept(4);
        i = 0;
        while (duty_o[0] != 4'd1 && i < 100) begin
            tick();
            i++;
        end
        chk("t6_first_step", int'(duty_o[0]), 1);
        repeat (20) tick();
        enable = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            chk("t6_frozen_duty", int'(duty_o[0]), 1);
            chk("t6_frozen_busy", int'(busy_o[0]), 1);
        end
        enable = 1'b1;
        repeat (11) tick();
        chk("t6_resume_before_step", int'(duty_o[0]), 1);
        tick();
        chk("t6_resume_step", int'(duty_o[0]), 2);

        // reset in the middle of the ramp
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_duty1", int'(duty_o[0]), 0);
        chk("t6_rst_duty2", int'(duty_o[1]), 0);
        chk("t6_rst_busy", int'(busy_o[0]), 0);
        chk("t6_rst_done", int'(done_o[0]), 0);
        chk("t6_rst_ready", int'(ready_o[0]), 1);
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
